serial_parity_frame_checker: RTL and testbench
==============================================

// Module: serial_parity_frame_checker
// PURPOSE
//  Parametrised successor to the single-bit even-parity detector. Deframes a serial stream
//  (start bit, DATA_W data bits LSB-first, parity bit, stop bit) qualified by bit_valid.
//  Checks even or odd parity per frame and flags parity and framing errors.
//  Sits after the serial line sampler; feeds the frame consumer and status logic.
// PARAMETERS
//  DATA_W  8  data bits per frame (1..32)
//  CNT_W   8  width of saturating error counter
// PORTS
//  clk          in   1       clock, rising edge
//  reset        in   1       synchronous, active-high
//  bit_valid    in   1       bit_in is a sampled bit this cycle
//  bit_in       in   1       serial data bit
//  odd_mode     in   1       0 = even parity, 1 = odd parity; latched at start bit
//  cnt_clr      in   1       clear err_count
//  busy         out  1       frame in progress (state != IDLE)
//  frame_valid  out  1       one-cycle pulse: frame complete, outputs below updated
//  data_out     out  DATA_W  received data word, held until next frame_valid
//  parity_err   out  1       parity mismatch of last frame, held
//  framing_err  out  1       stop bit was 0 in last frame, held
//  err_count    out  CNT_W   frames with parity_err|framing_err, saturating
// BEHAVIOUR
//  Reset: state=IDLE; busy=0, frame_valid=0, data_out=0, parity_err=0, framing_err=0, err_count=0.
//  State only advances on cycles with bit_valid=1; bit_valid=0 holds all state.
//  FSM:
//   - IDLE: bit_in=0 -> DATA; bit_cnt=0, acc=0, mode_q=odd_mode. bit_in=1 ignored (line idle).
//   - DATA: shift bit_in into data_q[bit_cnt], acc^=bit_in; at bit_cnt==DATA_W-1 -> PARITY.
//   - PARITY: par_bad = acc ^ bit_in ^ mode_q (even: total XOR must be 0; odd: must be 1) -> STOP.
//   - STOP: register data_out=data_q, parity_err=par_bad, framing_err=~bit_in;
//     pulse frame_valid the next cycle (1-cycle latency from accepted stop bit); -> IDLE.
//  A start bit arriving in the cycle frame_valid is high is accepted (back-to-back frames).
//  Framing error: frame is still reported; data_out is updated regardless.
//  odd_mode changes mid-frame have no effect; the latched mode_q is used.
//  Reset mid-frame: frame discarded, no frame_valid, outputs return to reset values.
//  bit_cnt is $clog2(DATA_W)+1 bits wide; it never wraps inside a frame.
// CONFIGURATION
//  PARITY_ERR_CNT_EN defined: err_count increments on frame_valid when parity_err|framing_err.
//   - Saturates at 2**CNT_W-1.
//   - cnt_clr zeroes it next cycle; cnt_clr beats a simultaneous increment.
//  PARITY_ERR_CNT_EN undefined: counter not built; err_count tied to 0; cnt_clr ignored.
// STRUCTURE
//  Package serial_parity_pkg:
//   - typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} frame_state_t
//   - typedef enum logic {PAR_EVEN=0, PAR_ODD=1} parity_mode_t
//   - localparam START_BIT=1'b0, STOP_BIT=1'b1
//  Sub-module parity_accum: running XOR with clear/enable, 1-bit out; used for acc.
// TESTING (DATA_W=8, bit_valid every cycle unless stated)
//  1. even, data 8'hA5, parity 0, stop 1 -> frame_valid 1 cycle, data_out=A5, both errs 0.
//  2. even, data 8'h01, parity 0 -> parity_err=1; err_count 0->1 (macro on), stays 0 (off).
//  3. odd, data 8'h03, parity 1, stop 0 -> parity_err=0, framing_err=1.
//  4. bit_valid low 3 cycles between every bit of 8'h3C -> same result as continuous stream.
//  5. reset after 4 data bits, then frame 8'hFF par 0 -> only one frame_valid, data_out=FF.
//  6. CNT_W=2, 5 bad frames, cnt_clr with 6th bad frame -> count 3 (saturated), then 0.

Source files
------------

// File: rtl/serial_parity_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_parity_pkg
// Purpose  : Shared types and constants for the serial parity frame checker:
//            frame FSM state encoding, parity mode encoding and line-level
//            start/stop bit values.
// Revision : 1.0 - initial release
// ============================================================================
package serial_parity_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } frame_state_t;

    typedef enum logic {
        PAR_EVEN = 1'b0,
        PAR_ODD  = 1'b1
    } parity_mode_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/serial_parity_frame_checker_parity_accum.sv
`default_nettype none
// ============================================================================
// Module   : parity_accum
// Purpose  : Running XOR of a serial bit stream with synchronous clear and
//            enable. Clear has priority over enable.
// Ports    : clk, reset (sync, active-high), clr, en, bit_in -> acc
// Revision : 1.0 - initial release
// ============================================================================
module parity_accum (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    input  logic bit_in,
    output logic acc
);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            acc <= 1'b0;
        end else if (en) begin
            acc <= acc ^ bit_in;
        end
    end

endmodule
`default_nettype wire

// File: rtl/serial_parity_frame_checker.sv
`default_nettype none
// ============================================================================
// Module   : serial_parity_frame_checker
// Purpose  : Deframes a bit_valid-qualified serial stream (start bit, DATA_W
//            data bits LSB-first, parity bit, stop bit), checks even/odd
//            parity and flags parity and framing errors.
// Ports    : clk, reset (sync, active-high), bit_valid, bit_in, odd_mode,
//            cnt_clr -> busy, frame_valid, data_out, parity_err, framing_err,
//            err_count
// Options  : PARITY_ERR_CNT_EN - build the saturating error-frame counter;
//            otherwise err_count is tied to 0 and cnt_clr is ignored.
// Revision : 1.0 - initial release
// ============================================================================
module serial_parity_frame_checker
    import serial_parity_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bit_valid,
    input  logic              bit_in,
    input  logic              odd_mode,
    input  logic              cnt_clr,
    output logic              busy,
    output logic              frame_valid,
    output logic [DATA_W-1:0] data_out,
    output logic              parity_err,
    output logic              framing_err,
    output logic [CNT_W-1:0]  err_count
);

    // One extra bit so the counter can hold DATA_W-1 for any DATA_W.
    localparam int                     c_BIT_CNT_W = $clog2(DATA_W) + 1;
    localparam logic [c_BIT_CNT_W-1:0] c_LAST_BIT  = c_BIT_CNT_W'(DATA_W - 1);

    frame_state_t             r_state;
    frame_state_t             w_state_next;
    logic [c_BIT_CNT_W-1:0]   r_bit_cnt;
    logic [DATA_W-1:0]        r_data;
    parity_mode_t             r_mode;
    logic                     r_par_bad;
    logic                     w_acc;
    logic                     w_start;
    logic                     w_acc_en;

    assign w_start  = (r_state == IDLE) && bit_valid && (bit_in == START_BIT);
    assign w_acc_en = (r_state == DATA) && bit_valid;
    assign busy     = (r_state != IDLE);

    parity_accum u_parity_accum (
        .clk    (clk),
        .reset  (reset),
        .clr    (w_start),
        .en     (w_acc_en),
        .bit_in (bit_in),
        .acc    (w_acc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (bit_valid) begin
            case (r_state)
                IDLE:    if (bit_in == START_BIT) w_state_next = DATA;
                DATA:    if (r_bit_cnt == c_LAST_BIT) w_state_next = PARITY;
                PARITY:  w_state_next = STOP;
                STOP:    w_state_next = IDLE;
                default: w_state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bit_cnt   <= '0;
            r_data      <= '0;
            r_mode      <= PAR_EVEN;
            r_par_bad   <= 1'b0;
            data_out    <= '0;
            parity_err  <= 1'b0;
            framing_err <= 1'b0;
            frame_valid <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            if (bit_valid) begin
                case (r_state)
                    IDLE: begin
                        if (bit_in == START_BIT) begin
                            r_bit_cnt <= '0;
                            r_mode    <= parity_mode_t'(odd_mode);
                        end
                    end
                    DATA: begin
                        // Every data bit is rewritten each frame, so r_data needs no clear.
                        for (int i = 0; i < DATA_W; i++) begin
                            if (r_bit_cnt == c_BIT_CNT_W'(i)) begin
                                r_data[i] <= bit_in;
                            end
                        end
                        if (r_bit_cnt != c_LAST_BIT) begin
                            r_bit_cnt <= r_bit_cnt + c_BIT_CNT_W'(1);
                        end
                    end
                    PARITY: begin
                        // Data XOR parity must equal 0 (even) or 1 (odd).
                        r_par_bad <= w_acc ^ bit_in ^ (r_mode == PAR_ODD);
                    end
                    STOP: begin
                        data_out    <= r_data;
                        parity_err  <= r_par_bad;
                        framing_err <= (bit_in != STOP_BIT);
                        frame_valid <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef PARITY_ERR_CNT_EN
    logic [CNT_W-1:0] r_err_count;

    // Counts on the frame_valid cycle, when the error flags already hold the
    // new frame's status. Clear wins over a coincident increment.
    always_ff @(posedge clk) begin
        if (reset || cnt_clr) begin
            r_err_count <= '0;
        end else if (frame_valid && (parity_err || framing_err) && (r_err_count != {CNT_W{1'b1}})) begin
            r_err_count <= r_err_count + CNT_W'(1);
        end
    end

    assign err_count = r_err_count;
`else
    logic w_unused_cnt_clr;
    assign w_unused_cnt_clr = cnt_clr;
    assign err_count        = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_parity_frame_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_parity_frame_checker
// Purpose  : Self-checking bench for serial_parity_frame_checker (DATA_W=8,
//            CNT_W=2). A frame-level model predicts every output each cycle;
//            literal checks pin key results.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_parity_frame_checker;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 2;
`ifdef PARITY_ERR_CNT_EN
    localparam bit c_HAS_CNT = 1'b1;
`else
    localparam bit c_HAS_CNT = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              bit_valid;
    logic              bit_in;
    logic              odd_mode;
    logic              cnt_clr;
    logic              busy;
    logic              frame_valid;
    logic [DATA_W-1:0] data_out;
    logic              parity_err;
    logic              framing_err;
    logic [CNT_W-1:0]  err_count;

    serial_parity_frame_checker #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .bit_valid   (bit_valid),
        .bit_in      (bit_in),
        .odd_mode    (odd_mode),
        .cnt_clr     (cnt_clr),
        .busy        (busy),
        .frame_valid (frame_valid),
        .data_out    (data_out),
        .parity_err  (parity_err),
        .framing_err (framing_err),
        .err_count   (err_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cycle   = 0;

    always @(posedge clk) cycle <= cycle + 1;

    // Frame-level model state
    int          exp_fv_cycle = -1;
    int          busy_start   = 0;
    int          busy_end     = -1;
    logic [7:0]  p_data = '0, m_data = '0;
    logic        p_perr = 0, p_ferr = 0, m_perr = 0, m_ferr = 0;
    int          m_cnt    = 0;
    int          fv_seen  = 0;
    bit          checking = 0;
    bit          fv_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    always @(negedge clk) begin
        if (checking) begin
            fv_exp = (cycle == exp_fv_cycle);
            if (fv_exp) begin
                m_data = p_data;
                m_perr = p_perr;
                m_ferr = p_ferr;
            end
            check("frame_valid", {31'd0, frame_valid}, {31'd0, fv_exp});
            check("busy", {31'd0, busy}, {31'd0, (cycle >= busy_start) && (cycle <= busy_end)});
            check("data_out", {24'd0, data_out}, {24'd0, m_data});
            check("parity_err", {31'd0, parity_err}, {31'd0, m_perr});
            check("framing_err", {31'd0, framing_err}, {31'd0, m_ferr});
            check("err_count", {30'd0, err_count}, m_cnt);
            if (frame_valid === 1'b1) fv_seen++;
            if (reset) begin
                m_data = '0; m_perr = 0; m_ferr = 0; m_cnt = 0;
                exp_fv_cycle = -1;
            end else if (c_HAS_CNT && cnt_clr) begin
                m_cnt = 0;
            end else if (c_HAS_CNT && fv_exp && (m_perr || m_ferr) && m_cnt < (2**CNT_W - 1)) begin
                m_cnt++;
            end
        end
    end

    // One sampled bit, then 'gap' invalid cycles carrying garbage on the inputs.
    task automatic drive(input logic b, input int gap);
        bit_valid = 1'b1;
        bit_in    = b;
        @(posedge clk); #1;
        repeat (gap) begin
            bit_valid = 1'b0;
            bit_in    = ~b;
            odd_mode  = ~odd_mode;
            @(posedge clk); #1;
        end
        bit_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            bit_valid = 1'b1;
            bit_in    = 1'b1;
            @(posedge clk); #1;
        end
        bit_valid = 1'b0;
    endtask

    // Returns in the cycle frame_valid is expected high.
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stp,
                              input logic mode, input int gap);
        odd_mode   = mode;
        busy_start = cycle + 1;
        busy_end   = 32'h7fff_ffff;
        drive(1'b0, gap);
        odd_mode = ~mode;
        for (int i = 0; i < 8; i++) drive(d[i], gap);
        drive(par, gap);
        p_data       = d;
        p_perr       = (^d) ^ par ^ mode;
        p_ferr       = ~stp;
        exp_fv_cycle = cycle + 1;
        busy_end     = cycle;
        drive(stp, 0);
        odd_mode = 1'b0;
    endtask

    task automatic resync();
        @(posedge clk); #1;
    endtask

    task automatic at_negedge();
        @(negedge clk); #1;
    endtask

    int fv0;

    initial begin
        reset = 1'b1; bit_valid = 1'b0; bit_in = 1'b1; odd_mode = 1'b0; cnt_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset    = 1'b0;
        checking = 1'b1;
        at_negedge();
        check("reset data_out", {24'd0, data_out}, 32'h0);
        check("reset busy", {31'd0, busy}, 32'h0);
        resync();
        idle(2);

        // 1: clean even frame
        send_frame(8'hA5, 1'b0, 1'b1, 1'b0, 0);
        at_negedge();
        check("t1 fv", {31'd0, frame_valid}, 32'h1);
        check("t1 data", {24'd0, data_out}, 32'hA5);
        check("t1 perr", {31'd0, parity_err}, 32'h0);
        check("t1 ferr", {31'd0, framing_err}, 32'h0);
        resync();
        idle(1);

        // 2: parity error
        send_frame(8'h01, 1'b0, 1'b1, 1'b0, 0);
        at_negedge();
        check("t2 perr", {31'd0, parity_err}, 32'h1);
        resync();
        at_negedge();
        check("t2 cnt", {30'd0, err_count}, c_HAS_CNT ? 32'd1 : 32'd0);
        resync();

        // 3: odd mode, good parity, bad stop
        send_frame(8'h03, 1'b1, 1'b0, 1'b1, 0);
        at_negedge();
        check("t3 perr", {31'd0, parity_err}, 32'h0);
        check("t3 ferr", {31'd0, framing_err}, 32'h1);
        check("t3 data", {24'd0, data_out}, 32'h03);
        resync();
        idle(2);

        // back-to-back frames: second start bit in the frame_valid cycle
        send_frame(8'h5A, 1'b0, 1'b1, 1'b0, 0);
        send_frame(8'h96, 1'b0, 1'b1, 1'b0, 0);
        at_negedge();
        check("b2b data", {24'd0, data_out}, 32'h96);
        resync();

        // 4: 3 idle cycles between every bit
        send_frame(8'h3C, 1'b0, 1'b1, 1'b0, 3);
        at_negedge();
        check("t4 data", {24'd0, data_out}, 32'h3C);
        check("t4 perr", {31'd0, parity_err}, 32'h0);
        resync();

        // 5: reset after 4 data bits
        busy_start = cycle + 1;
        busy_end   = 32'h7fff_ffff;
        drive(1'b0, 0);
        for (int i = 0; i < 4; i++) drive(1'b1, 0);
        reset     = 1'b1;
        busy_end  = cycle;
        resync();
        resync();
        reset = 1'b0;
        fv0   = fv_seen;
        idle(1);
        send_frame(8'hFF, 1'b0, 1'b1, 1'b0, 0);
        at_negedge();
        check("t5 fv count", fv_seen - fv0, 32'd1);
        check("t5 data", {24'd0, data_out}, 32'hFF);
        resync();

        // 6: saturate counter, then clear coinciding with a bad frame
        for (int k = 0; k < 5; k++) send_frame(8'h01, 1'b0, 1'b1, 1'b0, 0);
        resync();
        at_negedge();
        check("t6 sat", {30'd0, err_count}, c_HAS_CNT ? 32'd3 : 32'd0);
        resync();
        send_frame(8'h01, 1'b0, 1'b1, 1'b0, 0);
        cnt_clr = 1'b1;
        resync();
        cnt_clr = 1'b0;
        at_negedge();
        check("t6 clr", {30'd0, err_count}, 32'd0);
        resync();
        idle(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
